fetch_controller: RTL

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller_if.sv | 30 +++
 rtl/fetch_controller.sv | 101 ++++++++++
 2 files changed

// File: rtl/fetch_controller_if.sv
// Bundle of the fetch controller's memory, decode and branch-resolution signals.
// master is the controller side; slave is the memory/decode/execute side.
interface fetch_controller_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [63:0] instr_pc;
    logic        branch_valid;
    logic        branch_taken;
    logic [63:0] branch_pc;
    logic [63:0] branch_imm;
    logic [63:0] pc_current;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc, pc_current,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               branch_valid, branch_taken, branch_pc, branch_imm
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc, pc_current,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               branch_valid, branch_taken, branch_pc, branch_imm
    );
endinterface

// File: rtl/fetch_controller.sv
// Single-outstanding instruction fetch FSM (REQ -> WAIT -> HOLD) with branch redirect
// and kill of an in-flight fetch whose response must be discarded.
module fetch_controller #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                 clock,
    input  logic                 reset,
    fetch_controller_if.master   bus
);
    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] redirect_q, redirect_d;
    logic        kill_q, kill_d;
    logic [31:0] instr_data_q, instr_data_d;
    logic [63:0] instr_pc_q, instr_pc_d;

    logic        redirect;
    logic [63:0] target;

    assign redirect = bus.branch_valid && bus.branch_taken;
    assign target   = bus.branch_pc + bus.branch_imm;

    assign bus.imem_req_valid = (state_q == ST_REQ);
    assign bus.imem_req_addr  = pc_q;
    assign bus.pc_current     = pc_q;
    assign bus.instr_valid    = (state_q == ST_HOLD);
    assign bus.instr_data     = instr_data_q;
    assign bus.instr_pc       = instr_pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redirect_d   = redirect_q;
        kill_d       = kill_q;
        instr_data_d = instr_data_q;
        instr_pc_d   = instr_pc_q;
        case (state_q)
            ST_REQ: begin
                if (bus.imem_req_ready) begin
                    state_d = ST_WAIT;
                    if (redirect) begin
                        redirect_d = target;
                        kill_d     = 1'b1;
                    end
                end else if (redirect) begin
                    pc_d = target;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    // A response racing a fresh redirect is stale too; the request is
                    // retired either way, so restart fetching at the newest target.
                    if (kill_q || redirect) begin
                        pc_d    = redirect ? target : redirect_q;
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        instr_data_d = bus.imem_rsp_data;
                        instr_pc_d   = pc_q;
                        state_d      = ST_HOLD;
                    end
                end else if (redirect) begin
                    redirect_d = target;
                    kill_d     = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = ST_REQ;
                end else if (bus.instr_ready) begin
                    pc_d    = pc_q + 64'd4;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            redirect_q   <= 64'h0;
            kill_q       <= 1'b0;
            instr_data_q <= 32'h0;
            instr_pc_q   <= 64'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redirect_q   <= redirect_d;
            kill_q       <= kill_d;
            instr_data_q <= instr_data_d;
            instr_pc_q   <= instr_pc_d;
        end
    end
endmodule
